// File: rtl/scene_buffer.sv
// rtl/scene_buffer.sv - double-buffered scene object store with frame-synchronous bank swap
//
// Purpose: holds two banks of scene objects. The tracer reads the active bank
// while the loader fills the shadow bank. A commit arms a swap, and the swap is
// taken on the next frame_sync.
//
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset
//   load_start       pulse: rewind shadow write pointer, clear load_overflow
//   load_obj/valid   object stream into the shadow bank; load_ready accepts
//   load_commit      pulse: shadow contents become the pending scene
//   load_overflow    sticky: a write was dropped because the shadow bank was full
//   frame_sync       pulse at a frame boundary; performs an armed swap
//   swap_pending     a commit is waiting for frame_sync
//   obj_idx          read address (1-cycle latency to obj/obj_last)
//   obj, obj_last    registered read data, final-object flag
//   num_objs_active  object count of the active bank

package scene_buffer_pkg;
   localparam int SCENE_BUFFER_DEPTH = 8;
   typedef logic [31:0] object;
endpackage

module scene_buffer
   import scene_buffer_pkg::*;
#(
   parameter int DEPTH = SCENE_BUFFER_DEPTH,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  object         load_obj,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic          load_commit,
   output logic          load_overflow,
   input  logic          frame_sync,
   output logic          swap_pending,
   input  logic [IW-1:0] obj_idx,
   output object         obj,
   output logic          obj_last,
   output logic [IW:0]   num_objs_active
);

   typedef enum logic {FILL, PENDING} state_t;

   localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

   state_t      state, state_nxt;
   logic        bank_sel, bank_sel_nxt;
   logic [IW:0] wr_ptr, wr_ptr_nxt;
   logic        overflow_nxt;
   logic        wr_en;
   logic        commit;
   logic [IW:0] cnt [2];

   logic [IW:0] cnt_active;
   logic [IW:0] idx_ext;
   logic        rd_hit;
   logic        rd_last;
   object       rd_data;

   // Entry {bank, index}; the shadow bank is always ~bank_sel.
   object mem [2*DEPTH];

   // ---------------------------------------------------------------
   // Load / swap control
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bank_sel_nxt = bank_sel;
      wr_ptr_nxt   = wr_ptr;
      overflow_nxt = load_overflow;
      wr_en        = 1'b0;
      commit       = 1'b0;
      case (state)
         FILL: begin
            // load_start wins over a same-cycle object, which is then not written.
            if (load_start) begin
               wr_ptr_nxt   = '0;
               overflow_nxt = 1'b0;
            end else if (load_valid) begin
               if (wr_ptr < DEPTH_C) begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = wr_ptr + 1'b1;
               end else begin
                  overflow_nxt = 1'b1;
               end
            end
            // The committed count includes a transfer made in the same cycle.
            if (load_commit) begin
               commit    = 1'b1;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (frame_sync) begin
               bank_sel_nxt = ~bank_sel;
               wr_ptr_nxt   = '0;
               state_nxt    = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_sel      <= 1'b0;
         wr_ptr        <= '0;
         load_overflow <= 1'b0;
         cnt[0]        <= '0;
         cnt[1]        <= '0;
         load_ready    <= 1'b1;
         swap_pending  <= 1'b0;
      end else begin
         bank_sel      <= bank_sel_nxt;
         wr_ptr        <= wr_ptr_nxt;
         load_overflow <= overflow_nxt;
         if (commit) begin
            cnt[~bank_sel] <= wr_ptr_nxt;
         end
         // Registered from next-state so both flags track state with no extra lag.
         load_ready   <= (state_nxt == FILL) && (wr_ptr_nxt < DEPTH_C);
         swap_pending <= (state_nxt == PENDING);
      end
   end

   // Bank RAM is not reset; counts gate what the tracer can see.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{~bank_sel, wr_ptr[IW-1:0]}] <= load_obj;
      end
   end

   // ---------------------------------------------------------------
   // Tracer read port
   // ---------------------------------------------------------------
   assign cnt_active      = cnt[bank_sel];
   assign num_objs_active = cnt_active;
   assign idx_ext         = {1'b0, obj_idx};
   assign rd_hit          = idx_ext < cnt_active;
   // idx + 1 cannot wrap in IW+1 bits, so an empty scene flags every index as last.
   assign rd_last         = (idx_ext + 1'b1) >= cnt_active;
   assign rd_data         = mem[{bank_sel, obj_idx}];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obj      <= '0;
         obj_last <= 1'b1;
      end else begin
         obj      <= rd_hit ? rd_data : '0;
         obj_last <= rd_last;
      end
   end

endmodule

// File: tb/tb_scene_buffer.sv
// tb/tb_scene_buffer.sv - scoreboard testbench for scene_buffer
module tb_scene_buffer;
   import scene_buffer_pkg::*;

   localparam int DEPTH = SCENE_BUFFER_DEPTH;
   localparam int IW    = $clog2(DEPTH);

   typedef struct packed {
      object o;
      logic  last;
   } rd_t;

   logic          clk;
   logic          rst_n;
   logic          load_start;
   object         load_obj;
   logic          load_valid;
   logic          load_ready;
   logic          load_commit;
   logic          load_overflow;
   logic          frame_sync;
   logic          swap_pending;
   logic [IW-1:0] obj_idx;
   object         obj;
   logic          obj_last;
   logic [IW:0]   num_objs_active;

   scene_buffer #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .load_start      (load_start),
      .load_obj        (load_obj),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_commit     (load_commit),
      .load_overflow   (load_overflow),
      .frame_sync      (frame_sync),
      .swap_pending    (swap_pending),
      .obj_idx         (obj_idx),
      .obj             (obj),
      .obj_last        (obj_last),
      .num_objs_active (num_objs_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  checks = 0;
   int  errors = 0;
   rd_t exp_q[$];

   // Reference model of the scene store
   object m_bank [2][DEPTH];
   int    m_cnt  [2];
   bit    m_sel;
   bit    m_pend;
   bit    m_ovf;
   int    m_wp;

   function automatic rd_t exp_read(input int idx);
      rd_t r;
      int  c;
      c      = m_cnt[m_sel];
      r.o    = (idx < c) ? m_bank[m_sel][idx] : '0;
      r.last = (idx + 1 >= c);
      return r;
   endfunction

   function automatic object rnd_obj();
      return object'($urandom) | object'(1);
   endfunction

   task automatic model_reset();
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_sel    = 1'b0;
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_wp     = 0;
   endtask

   // Drive one cycle of loader/frame inputs, advance the model, wait for the edge.
   task automatic step(input logic v, input object o, input logic st, input logic cm, input logic fs);
      load_valid  = v;
      load_obj    = o;
      load_start  = st;
      load_commit = cm;
      frame_sync  = fs;
      if (!m_pend) begin
         if (st) begin
            m_wp  = 0;
            m_ovf = 1'b0;
         end else if (v) begin
            if (m_wp < DEPTH) begin
               m_bank[~m_sel][m_wp] = o;
               m_wp++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (cm) begin
            m_cnt[~m_sel] = m_wp;
            m_pend        = 1'b1;
         end
      end else if (fs) begin
         m_sel  = ~m_sel;
         m_wp   = 0;
         m_pend = 1'b0;
      end
      @(negedge clk);
      load_valid  = 1'b0;
      load_obj    = '0;
      load_start  = 1'b0;
      load_commit = 1'b0;
      frame_sync  = 1'b0;
   endtask

   task automatic test_reset();
      rd_t e;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (load_ready !== 1'b1 || load_overflow !== 1'b0 || swap_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: ready=%b ovf=%b pend=%b expected 1 0 0", load_ready, load_overflow, swap_pending);
      end
      checks++;
      if (num_objs_active !== '0 || obj !== '0 || obj_last !== 1'b1) begin
         errors++;
         $display("FAIL reset_read_regs: num=%0d obj=%h last=%b expected 0 0 1", num_objs_active, obj, obj_last);
      end
      obj_idx = '0;
      exp_q.push_back(exp_read(0));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obj !== e.o || obj_last !== e.last) begin
         errors++;
         $display("FAIL reset_read_idx0: obj=%h last=%b expected %h %b", obj, obj_last, e.o, e.last);
      end
   endtask

   task automatic test_load_swap();
      rd_t e;
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (swap_pending !== 1'b1 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_swap_pending: pend=%b ready=%b expected 1 0", swap_pending, load_ready);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (num_objs_active !== (IW+1)'(3) || swap_pending !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_swap_count: num=%0d pend=%b ready=%b expected 3 0 1", num_objs_active, swap_pending, load_ready);
      end
      for (int i = 0; i < 3; i++) begin
         obj_idx = IW'(i);
         exp_q.push_back(exp_read(i));
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obj !== e.o || obj_last !== e.last) begin
            errors++;
            $display("FAIL load_swap_read%0d: obj=%h last=%b expected %h %b", i, obj, obj_last, e.o, e.last);
         end
      end
   endtask

   task automatic test_consistency();
      rd_t e;
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      // Stream idx 0 every cycle; frame_sync lands with the read of cycle 3.
      for (int i = 0; i < 7; i++) begin
         obj_idx = '0;
         exp_q.push_back(exp_read(0));
         step(1'b0, '0, 1'b0, 1'b0, (i == 3));
         e = exp_q.pop_front();
         checks++;
         if (obj !== e.o || obj_last !== e.last || e.last !== (i > 3)) begin
            errors++;
            $display("FAIL consistency_read%0d: obj=%h last=%b expected %h %b", i, obj, obj_last, e.o, (i > 3));
         end
      end
   endtask

   task automatic test_overflow();
      rd_t e;
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      checks++;
      if (load_ready !== 1'b0 || load_overflow !== m_ovf || m_ovf !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flags: ready=%b ovf=%b expected 0 1", load_ready, load_overflow);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (num_objs_active !== (IW+1)'(DEPTH)) begin
         errors++;
         $display("FAIL overflow_count: num=%0d expected %0d", num_objs_active, DEPTH);
      end
      for (int i = DEPTH - 2; i < DEPTH; i++) begin
         obj_idx = IW'(i);
         exp_q.push_back(exp_read(i));
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obj !== e.o || obj_last !== e.last) begin
            errors++;
            $display("FAIL overflow_read%0d: obj=%h last=%b expected %h %b", i, obj, obj_last, e.o, e.last);
         end
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (load_overflow !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL overflow_clear: ovf=%b ready=%b expected 0 1", load_overflow, load_ready);
      end
   endtask

   task automatic test_edge_cases();
      rd_t e;
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (num_objs_active !== '0) begin
         errors++;
         $display("FAIL empty_count: num=%0d expected 0", num_objs_active);
      end
      for (int i = 0; i < DEPTH; i += 3) begin
         obj_idx = IW'(i);
         exp_q.push_back(exp_read(i));
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obj !== '0 || obj_last !== 1'b1 || e.o !== '0) begin
            errors++;
            $display("FAIL empty_read%0d: obj=%h last=%b expected 0 1", i, obj, obj_last);
         end
      end
      // Second object arrives with the commit in the same cycle.
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (num_objs_active !== (IW+1)'(2)) begin
         errors++;
         $display("FAIL commit_same_cycle_count: num=%0d expected 2", num_objs_active);
      end
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (k == 2) ? 5 : k;
         obj_idx = IW'(idx);
         exp_q.push_back(exp_read(idx));
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obj !== e.o || obj_last !== e.last) begin
            errors++;
            $display("FAIL two_obj_read%0d: obj=%h last=%b expected %h %b", idx, obj, obj_last, e.o, e.last);
         end
      end
      // Commit and frame_sync together: the swap must wait for the next frame_sync.
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, rnd_obj(), 1'b0, 1'b1, 1'b1);
      checks++;
      if (swap_pending !== 1'b1 || num_objs_active !== (IW+1)'(2)) begin
         errors++;
         $display("FAIL commit_sync_same: pend=%b num=%0d expected 1 2", swap_pending, num_objs_active);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (swap_pending !== 1'b0 || num_objs_active !== (IW+1)'(m_cnt[m_sel])) begin
         errors++;
         $display("FAIL commit_sync_late_swap: pend=%b num=%0d expected 0 %0d", swap_pending, num_objs_active, m_cnt[m_sel]);
      end
   endtask

   task automatic test_async_reset();
      rd_t e;
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, rnd_obj(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      obj_idx = '0;
      exp_q.push_back(exp_read(0));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obj !== e.o || obj_last !== e.last || swap_pending !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_state: obj=%h last=%b pend=%b expected %h %b 1", obj, obj_last, swap_pending, e.o, e.last);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obj !== '0 || obj_last !== 1'b1 || num_objs_active !== '0 ||
          swap_pending !== 1'b0 || load_ready !== 1'b1 || load_overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: obj=%h last=%b num=%0d pend=%b ready=%b ovf=%b expected 0 1 0 0 1 0",
                  obj, obj_last, num_objs_active, swap_pending, load_ready, load_overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (swap_pending !== 1'b0 || num_objs_active !== '0) begin
         errors++;
         $display("FAIL post_reset_sync: pend=%b num=%0d expected 0 0", swap_pending, num_objs_active);
      end
      obj_idx = '0;
      exp_q.push_back(exp_read(0));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obj !== e.o || obj_last !== e.last) begin
         errors++;
         $display("FAIL post_reset_read: obj=%h last=%b expected %h %b", obj, obj_last, e.o, e.last);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      load_start  = 1'b0;
      load_obj    = '0;
      load_valid  = 1'b0;
      load_commit = 1'b0;
      frame_sync  = 1'b0;
      obj_idx     = '0;
      model_reset();
      test_reset();
      test_load_swap();
      test_consistency();
      test_overflow();
      test_edge_cases();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
